// File: rtl/bram_rd_arb.sv
// Round-robin arbiter sharing one BRAM read port among NREQ requesters.
// A tag pipeline tracks the fixed read latency and routes data back to the issuer.
module bram_rd_arb #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned AW     = 10,
    parameter int unsigned DW     = 16,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                          CLK,
    input  logic                          RST_L,
    input  logic                          wr_active,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*AW-1:0]            req_addr,
    output logic [NREQ-1:0]               req_ready,
    output logic                          ram_re,
    output logic [AW-1:0]                 ram_addr,
    input  logic [DW-1:0]                 ram_dout,
    output logic [NREQ-1:0]               rsp_valid,
    output logic [DW-1:0]                 rsp_data,
    output logic [$clog2(RD_LAT+2)-1:0]   pend_cnt
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned PW = $clog2(RD_LAT + 2);

    logic [IW-1:0]   ptr_q, ptr_d;
    logic            gnt_vld_c;
    logic [IW-1:0]   gnt_id_c;

    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [IW-1:0]     tag_id_q [RD_LAT];
    logic [IW-1:0]     tag_id_d [RD_LAT];

    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic [PW-1:0]   pend_cnt_q, pend_cnt_d;

    // Search from ptr upward, wrapping; reset and write ownership suppress any grant.
    always_comb begin
        int idx;
        gnt_vld_c = 1'b0;
        gnt_id_c  = '0;
        idx       = 0;
        if (RST_L && !wr_active) begin
            for (int k = 0; k < int'(NREQ); k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= int'(NREQ)) begin
                    idx = idx - int'(NREQ);
                end
                if (!gnt_vld_c && req_valid[IW'(idx)]) begin
                    gnt_vld_c = 1'b1;
                    gnt_id_c  = IW'(idx);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        ram_re    = gnt_vld_c;
        ram_addr  = '0;
        if (gnt_vld_c) begin
            req_ready = NREQ'(1) << gnt_id_c;
            ram_addr  = req_addr[int'(gnt_id_c)*int'(AW) +: AW];
        end
    end

    // Next-state: pointer, tag shift, response capture, outstanding count.
    always_comb begin
        ptr_d       = ptr_q;
        tag_vld_d   = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        pend_cnt_d  = pend_cnt_q;
        for (int k = 0; k < int'(RD_LAT); k++) begin
            tag_id_d[k] = '0;
        end

        if (gnt_vld_c) begin
            ptr_d = (gnt_id_c == IW'(NREQ - 1)) ? '0 : gnt_id_c + IW'(1);
        end

        tag_vld_d[0] = gnt_vld_c;
        tag_id_d[0]  = gnt_id_c;
        for (int k = 1; k < int'(RD_LAT); k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_id_d[k]  = tag_id_q[k-1];
        end

        if (tag_vld_q[RD_LAT-1]) begin
            rsp_valid_d = NREQ'(1) << tag_id_q[RD_LAT-1];
            rsp_data_d  = ram_dout;
        end

        // A read leaves the count once its response has been presented.
        if (gnt_vld_c && !(|rsp_valid_q)) begin
            if (pend_cnt_q != PW'(RD_LAT + 1)) begin
                pend_cnt_d = pend_cnt_q + PW'(1);
            end
        end else if (!gnt_vld_c && (|rsp_valid_q)) begin
            if (pend_cnt_q != '0) begin
                pend_cnt_d = pend_cnt_q - PW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            ptr_q       <= '0;
            tag_vld_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            pend_cnt_q  <= '0;
            for (int k = 0; k < int'(RD_LAT); k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            tag_vld_q   <= tag_vld_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            pend_cnt_q  <= pend_cnt_d;
            for (int k = 0; k < int'(RD_LAT); k++) begin
                tag_id_q[k] <= tag_id_d[k];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign pend_cnt  = pend_cnt_q;

endmodule
